// File: rtl/fsm_ctrl_sequencer_pkg.sv
// Shared state encodings, mode codes and output bundle for the counter-FSM sequencer.
package fsm_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [1:0] X_M0 = 2'd0;
  localparam logic [1:0] X_M1 = 2'd1;
  localparam logic [1:0] X_M2 = 2'd2;
  localparam logic [1:0] X_M3 = 2'd3;

  typedef struct packed {
    logic [1:0] x;
    logic       en;
    logic       busy;
    logic       done;
  } ctrl_out_t;

  localparam ctrl_out_t OUT_IDLE = '{x: X_M0, en: 1'b0, busy: 1'b0, done: 1'b0};
  localparam ctrl_out_t OUT_DONE = '{x: X_M0, en: 1'b0, busy: 1'b0, done: 1'b1};

endpackage

// File: rtl/fsm_ctrl_sequencer_if.sv
// Host <-> sequencer bus: program/handshake inputs and counter-FSM drive outputs.
interface fsm_ctrl_sequencer_if #(
  parameter int NUM_STEPS = 4,
  parameter int DWELL_W   = 4
);
  localparam int STEP_W = $clog2(NUM_STEPS);

  logic                   start;
  logic                   abort;
  logic                   loop;
  logic [2*NUM_STEPS-1:0] seq;
  logic [DWELL_W-1:0]     dwell;
  logic [1:0]             x;
  logic                   en;
  logic                   busy;
  logic                   done;
  logic [STEP_W-1:0]      step;

  modport master (output start, abort, loop, seq, dwell,
                  input  x, en, busy, done, step);
  modport slave  (input  start, abort, loop, seq, dwell,
                  output x, en, busy, done, step);
endinterface

// File: rtl/fsm_ctrl_sequencer_dwell_counter.sv
// Per-step dwell counter: counts 0..limit-1, flags the last cycle and holds there.
module dwell_counter #(
  parameter int DWELL_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic [DWELL_W-1:0] i_limit,
  output logic               o_tc
);
  logic [DWELL_W-1:0] r_cnt;

  assign o_tc = (r_cnt == (i_limit - DWELL_W'(1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_cnt <= '0;
    else if (i_clear)            r_cnt <= '0;
    else if (i_enable && !o_tc)  r_cnt <= r_cnt + DWELL_W'(1);
  end
endmodule

// File: rtl/fsm_ctrl_sequencer.sv
// Moore sequencer that plays a shadowed program of mode codes into the counter FSM's X/En.
module fsm_ctrl_sequencer
  import fsm_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter int DWELL_W   = 4
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  fsm_ctrl_sequencer_if.slave   bus
);
  localparam int STEP_W = $clog2(NUM_STEPS);

  logic [1:0]             r_state;
  ctrl_out_t              r_out;
  logic [STEP_W-1:0]      r_step;
  logic [2*NUM_STEPS-1:0] r_seq_q;
  logic [DWELL_W-1:0]     r_dwell_q;

  logic                   w_tc;
  logic                   w_last;
  logic                   w_clear;
  logic [STEP_W-1:0]      w_step_nxt;

  assign w_last     = (r_step == STEP_W'(NUM_STEPS - 1));
  assign w_step_nxt = r_step + STEP_W'(1);
  // Counter only runs in RUN; it restarts on every step boundary or abort.
  assign w_clear    = (r_state != ST_RUN) | w_tc | bus.abort;

  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_clear),
    .i_enable (r_state == ST_RUN),
    .i_limit  (r_dwell_q),
    .o_tc     (w_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_out     <= OUT_IDLE;
      r_step    <= '0;
      r_seq_q   <= '0;
      r_dwell_q <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_state   <= ST_RUN;
            r_seq_q   <= bus.seq;
            r_dwell_q <= (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
            r_step    <= '0;
            r_out     <= '{x: bus.seq[1:0], en: 1'b1, busy: 1'b1, done: 1'b0};
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_out   <= OUT_IDLE;
            r_step  <= '0;
          end else if (w_tc) begin
            if (!w_last) begin
              r_step  <= w_step_nxt;
              r_out.x <= r_seq_q[{w_step_nxt, 1'b0} +: 2];
            end else if (bus.loop) begin
              r_step  <= '0;
              r_out.x <= r_seq_q[1:0];
            end else begin
              r_state <= ST_DONE;
              r_out   <= OUT_DONE;
              r_step  <= '0;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_out   <= OUT_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_out   <= OUT_IDLE;
          r_step  <= '0;
        end
      endcase
    end
  end

  assign bus.x    = r_out.x;
  assign bus.en   = r_out.en;
  assign bus.busy = r_out.busy;
  assign bus.done = r_out.done;
  assign bus.step = r_step;
endmodule
